slink_ch_train_ctrl: RTL and testbench

Link-training controller that sequences slink_ch_alloc at bring-up and on demand.
- Forces the allocator into bypass and sends a known per-channel pattern on all channels.
- Checks what arrives on every RX channel and builds a good-channel mask.
- Clears the allocator, programs the mask into TX/RX channel_en, then leaves bypass.
- Sits between the register file / link FSM and the allocator's cfg_* inputs; muxes its training stream onto the allocator data_out port while busy.

---
 rtl/slink_ch_train_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_slink_ch_train_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/slink_ch_train_ctrl.sv
// Link-training controller for slink_ch_alloc: sends a known per-channel pattern in bypass,
// scores every RX channel, then programs the good-channel mask and leaves bypass.
module slink_ch_train_ctrl #(
  parameter int NumChannels   = 32,
  parameter int ElemWidth     = 16,
  parameter int NumTrainWords = 16,
  parameter int TimeoutCycles = 1024,
  parameter int MinChannels   = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic                             abort_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             fail_o,
  output logic [NumChannels-1:0]           good_mask_o,
  output logic                             cfg_tx_clear_o,
  output logic                             cfg_rx_clear_o,
  output logic [NumChannels-1:0]           cfg_channel_en_o,
  output logic                             cfg_bypass_en_o,
  output logic                             train_active_o,
  output logic [NumChannels*ElemWidth-1:0] train_data_o,
  output logic                             train_valid_o,
  input  logic                             train_ready_i,
  input  logic [NumChannels*ElemWidth-1:0] rx_data_i,
  input  logic [NumChannels-1:0]           rx_valid_i,
  output logic [NumChannels-1:0]           rx_ready_o
);

  localparam int CntW = 9;
  localparam int TmrW = $clog2(TimeoutCycles + 1);
  localparam int PopW = $clog2(NumChannels + 1);
  localparam logic [CntW-1:0] LastWord = CntW'(NumTrainWords - 1);
  localparam logic [CntW-1:0] NumWords = CntW'(NumTrainWords);
  localparam logic [TmrW-1:0] TmrLast  = TmrW'(TimeoutCycles - 1);
  localparam logic [PopW-1:0] MinGood  = PopW'(MinChannels);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SEND, S_WAIT_RX, S_EVAL, S_APPLY, S_DONE, S_FAIL
  } state_e;

  state_e                           r_state, w_nxt;
  logic [CntW-1:0]                  r_k;
  logic [TmrW-1:0]                  r_tmr;
  logic [CntW-1:0]                  r_rx_cnt [NumChannels];
  logic [NumChannels-1:0]           r_pass, r_good_mask, r_channel_en, r_rx_ready;
  logic                             r_busy, r_done, r_fail, r_clear, r_bypass;
  logic [NumChannels-1:0]           w_good, w_rx_hit, w_rx_match, w_rx_full;
  logic [NumChannels*ElemWidth-1:0] w_train_data;
  logic                             w_busy_state, w_abort, w_hs, w_all_rx, w_timeout;
  logic [PopW-1:0]                  w_pop;

  // Pattern word k on channel ch: {ch[7:0], k[7:0]} zero-extended to ElemWidth.
  function automatic logic [ElemWidth-1:0] exp_word(input int unsigned ch, input logic [CntW-1:0] idx);
    logic [ElemWidth-1:0] w;
    w       = '0;
    w[15:0] = {ch[7:0], idx[7:0]};
    return w;
  endfunction

  function automatic logic [PopW-1:0] popcount(input logic [NumChannels-1:0] v);
    logic [PopW-1:0] c;
    c = '0;
    for (int i = 0; i < NumChannels; i++) c = c + PopW'(v[i]);
    return c;
  endfunction

  // Per-channel pattern generation and RX scoring.
  always_comb begin
    w_all_rx     = 1'b1;
    w_good       = '0;
    w_rx_hit     = '0;
    w_rx_match   = '0;
    w_rx_full    = '0;
    w_train_data = '0;
    for (int i = 0; i < NumChannels; i++) begin
      w_rx_full[i]  = (r_rx_cnt[i] == NumWords);
      w_rx_hit[i]   = rx_valid_i[i] & r_rx_ready[i];
      w_rx_match[i] = (rx_data_i[i*ElemWidth +: ElemWidth] == exp_word(i, r_rx_cnt[i]));
      w_good[i]     = r_pass[i] & w_rx_full[i];
      w_train_data[i*ElemWidth +: ElemWidth] = exp_word(i, r_k);
      w_all_rx      = w_all_rx & w_rx_full[i];
    end
  end

  assign w_busy_state = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_FAIL);
  assign w_abort      = abort_i & w_busy_state;
  assign w_hs         = (r_state == S_SEND) & train_ready_i;
  assign w_timeout    = (r_tmr == TmrLast);
  assign w_pop        = popcount(w_good);

  // Next-state decode; abort from any busy state wins over everything else.
  always_comb begin
    w_nxt = r_state;
    if (w_abort) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start_i && !abort_i) w_nxt = S_CLEAR;
          else                     w_nxt = r_state;
        end
        S_CLEAR: w_nxt = S_SEND;
        S_SEND: begin
          if (w_timeout)                   w_nxt = S_EVAL;
          else if (w_hs && r_k == LastWord) w_nxt = S_WAIT_RX;
          else                             w_nxt = S_SEND;
        end
        S_WAIT_RX: begin
          if (w_timeout || w_all_rx) w_nxt = S_EVAL;
          else                       w_nxt = S_WAIT_RX;
        end
        S_EVAL: begin
          if (w_pop >= MinGood) w_nxt = S_APPLY;
          else                  w_nxt = S_FAIL;
        end
        S_APPLY: w_nxt = S_DONE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // State register and registered control outputs, all decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_clear      <= 1'b0;
      r_bypass     <= 1'b1;
      r_channel_en <= '1;
      r_rx_ready   <= '0;
      r_good_mask  <= '0;
    end else begin
      r_state    <= w_nxt;
      r_busy     <= (w_nxt != S_IDLE) && (w_nxt != S_DONE) && (w_nxt != S_FAIL);
      r_done     <= (w_nxt == S_DONE);
      r_fail     <= (w_nxt == S_FAIL);
      r_clear    <= w_abort || (w_nxt == S_CLEAR) || (w_nxt == S_APPLY);
      r_bypass   <= (w_nxt != S_DONE);
      r_rx_ready <= ((w_nxt == S_SEND) || (w_nxt == S_WAIT_RX)) ? '1 : '0;
      // The trained mask is only live while DONE; every other state runs all channels in bypass.
      if (w_nxt != S_DONE)       r_channel_en <= '1;
      else if (r_state == S_APPLY) r_channel_en <= r_good_mask;
      if (r_state == S_EVAL) r_good_mask <= w_good;
    end
  end

  // TX word index, timeout counter and per-channel RX scoreboard.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_k    <= '0;
      r_tmr  <= '0;
      r_pass <= '0;
      for (int i = 0; i < NumChannels; i++) r_rx_cnt[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      r_k    <= '0;
      r_tmr  <= '0;
      r_pass <= '1;
      for (int i = 0; i < NumChannels; i++) r_rx_cnt[i] <= '0;
    end else begin
      if (w_hs) r_k <= r_k + CntW'(1);
      if ((r_state == S_SEND) || (r_state == S_WAIT_RX)) r_tmr <= r_tmr + TmrW'(1);
      for (int i = 0; i < NumChannels; i++) begin
        if (w_rx_hit[i]) begin
          if (w_rx_full[i]) begin
            r_pass[i] <= 1'b0;
          end else begin
            if (!w_rx_match[i]) r_pass[i] <= 1'b0;
            r_rx_cnt[i] <= r_rx_cnt[i] + CntW'(1);
          end
        end
      end
    end
  end

  assign busy_o           = r_busy;
  assign train_active_o   = r_busy;
  assign done_o           = r_done;
  assign fail_o           = r_fail;
  assign good_mask_o      = r_good_mask;
  assign cfg_tx_clear_o   = r_clear;
  assign cfg_rx_clear_o   = r_clear;
  assign cfg_channel_en_o = r_channel_en;
  assign cfg_bypass_en_o  = r_bypass;
  assign rx_ready_o       = r_rx_ready;
  assign train_valid_o    = (r_state == S_SEND);
  assign train_data_o     = w_train_data;

endmodule

// File: tb/tb_slink_ch_train_ctrl.sv
// Directed bench for slink_ch_train_ctrl: the bench loops the training stream back onto
// the RX side one cycle later, optionally corrupting or dropping channels.
module tb_slink_ch_train_ctrl;

  localparam int NC = 32;
  localparam int EW = 16;
  localparam int DW = NC * EW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          busy_o, done_o, fail_o;
  logic [NC-1:0] good_mask_o;
  logic          cfg_tx_clear_o, cfg_rx_clear_o;
  logic [NC-1:0] cfg_channel_en_o;
  logic          cfg_bypass_en_o, train_active_o;
  logic [DW-1:0] train_data_o;
  logic          train_valid_o;
  logic          train_ready_i = 1'b1;
  logic [DW-1:0] rx_data_i = '0;
  logic [NC-1:0] rx_valid_i = '0;
  logic [NC-1:0] rx_ready_o;

  int total = 0;
  int bad = 0;
  int tx_idx = 0;
  int corrupt_ch = -1;
  int corrupt_word = -1;
  bit corrupt_all = 1'b0;
  logic [NC-1:0] valid_mask = '1;

  slink_ch_train_ctrl #(
    .NumChannels(NC), .ElemWidth(EW), .NumTrainWords(16), .TimeoutCycles(1024), .MinChannels(1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .good_mask_o(good_mask_o),
    .cfg_tx_clear_o(cfg_tx_clear_o), .cfg_rx_clear_o(cfg_rx_clear_o),
    .cfg_channel_en_o(cfg_channel_en_o), .cfg_bypass_en_o(cfg_bypass_en_o),
    .train_active_o(train_active_o), .train_data_o(train_data_o), .train_valid_o(train_valid_o),
    .train_ready_i(train_ready_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock: a word handshaken at this edge is looped back onto RX right after it.
  task automatic step();
    logic          hs;
    logic [DW-1:0] d;
    hs = train_valid_o && train_ready_i;
    d  = train_data_o;
    @(posedge clk_i);
    #1;
    if (hs) begin
      if (corrupt_all && tx_idx == 0)
        for (int c = 0; c < NC; c++) d[c*EW] = ~d[c*EW];
      if (corrupt_ch >= 0 && tx_idx == corrupt_word) d[corrupt_ch*EW] = ~d[corrupt_ch*EW];
      rx_data_i  = d;
      rx_valid_i = valid_mask;
      tx_idx++;
    end else begin
      rx_valid_i = '0;
    end
  endtask

  task automatic wait_end(input int budget, inout int cycles, inout int clears);
    while (!(done_o || fail_o) && cycles < budget) begin
      step();
      cycles++;
      if (cfg_tx_clear_o) clears++;
    end
  endtask

  task automatic run_training(input int budget, output int cycles, output int clears);
    tx_idx = 0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    cycles = 1;
    clears = cfg_tx_clear_o ? 1 : 0;
    wait_end(budget, cycles, clears);
    total++;
    if (!(done_o || fail_o)) begin bad++; $display("FAIL run_timeout: got no done/fail after %0d cycles", cycles); end
  endtask

  task automatic test_reset();
    total++; if (busy_o !== 1'b0 || train_active_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b/%0b expected 0", busy_o, train_active_o); end
    total++; if (done_o !== 1'b0 || fail_o !== 1'b0) begin bad++; $display("FAIL reset_done_fail: got %0b/%0b expected 0/0", done_o, fail_o); end
    total++; if (good_mask_o !== 32'h0) begin bad++; $display("FAIL reset_mask: got %0h expected 0", good_mask_o); end
    total++; if (cfg_channel_en_o !== 32'hFFFFFFFF || cfg_bypass_en_o !== 1'b1) begin bad++; $display("FAIL reset_cfg: got en=%0h byp=%0b expected ffffffff/1", cfg_channel_en_o, cfg_bypass_en_o); end
    total++; if (cfg_tx_clear_o !== 1'b0 || cfg_rx_clear_o !== 1'b0 || train_valid_o !== 1'b0 || rx_ready_o !== 32'h0) begin bad++; $display("FAIL reset_misc: got clr=%0b%0b tv=%0b rdy=%0h expected zeros", cfg_tx_clear_o, cfg_rx_clear_o, train_valid_o, rx_ready_o); end
  endtask

  task automatic test_ideal();
    int cyc, clr;
    run_training(100, cyc, clr);
    total++; if (done_o !== 1'b1 || fail_o !== 1'b0) begin bad++; $display("FAIL ideal_done: got done=%0b fail=%0b expected 1/0", done_o, fail_o); end
    total++; if (cyc > 30) begin bad++; $display("FAIL ideal_latency: got %0d cycles expected <=30", cyc); end
    total++; if (good_mask_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL ideal_mask: got %0h expected ffffffff", good_mask_o); end
    total++; if (cfg_channel_en_o !== 32'hFFFFFFFF || cfg_bypass_en_o !== 1'b0) begin bad++; $display("FAIL ideal_cfg: got en=%0h byp=%0b expected ffffffff/0", cfg_channel_en_o, cfg_bypass_en_o); end
    total++; if (clr != 2) begin bad++; $display("FAIL ideal_clears: got %0d pulses expected 2", clr); end
    total++; if (busy_o !== 1'b0 || train_valid_o !== 1'b0 || rx_ready_o !== 32'h0) begin bad++; $display("FAIL ideal_idle_outs: got busy=%0b tv=%0b rdy=%0h expected 0", busy_o, train_valid_o, rx_ready_o); end
  endtask

  task automatic test_corrupt_ch5();
    int cyc, clr;
    corrupt_ch = 5; corrupt_word = 3;
    run_training(100, cyc, clr);
    corrupt_ch = -1; corrupt_word = -1;
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL corrupt_done: got %0b expected 1", done_o); end
    total++; if (good_mask_o !== 32'hFFFFFFDF) begin bad++; $display("FAIL corrupt_mask: got %0h expected ffffffdf", good_mask_o); end
    total++; if (cfg_channel_en_o !== 32'hFFFFFFDF) begin bad++; $display("FAIL corrupt_en: got %0h expected ffffffdf", cfg_channel_en_o); end
  endtask

  task automatic test_abort();
    int cyc, clr, n;
    tx_idx = 0;
    start_i = 1'b1; step(); start_i = 1'b0;
    n = 0;
    while (tx_idx < 7 && n < 50) begin step(); n++; end
    abort_i = 1'b1; start_i = 1'b1;
    step();
    abort_i = 1'b0; start_i = 1'b0;
    total++; if (busy_o !== 1'b0 || train_valid_o !== 1'b0 || rx_ready_o !== 32'h0) begin bad++; $display("FAIL abort_idle: got busy=%0b tv=%0b rdy=%0h expected 0", busy_o, train_valid_o, rx_ready_o); end
    total++; if (cfg_tx_clear_o !== 1'b1 || cfg_rx_clear_o !== 1'b1) begin bad++; $display("FAIL abort_clear: got %0b%0b expected 11", cfg_tx_clear_o, cfg_rx_clear_o); end
    total++; if (cfg_channel_en_o !== 32'hFFFFFFFF || cfg_bypass_en_o !== 1'b1 || done_o !== 1'b0) begin bad++; $display("FAIL abort_cfg: got en=%0h byp=%0b done=%0b expected ffffffff/1/0", cfg_channel_en_o, cfg_bypass_en_o, done_o); end
    total++; if (good_mask_o !== 32'hFFFFFFDF) begin bad++; $display("FAIL abort_mask_hold: got %0h expected ffffffdf", good_mask_o); end
    step();
    total++; if (cfg_tx_clear_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL abort_single_pulse: got clr=%0b busy=%0b expected 0/0", cfg_tx_clear_o, busy_o); end
    run_training(100, cyc, clr);
    total++; if (done_o !== 1'b1 || good_mask_o !== 32'hFFFFFFFF || clr != 2) begin bad++; $display("FAIL abort_rerun: got done=%0b mask=%0h clears=%0d expected 1/ffffffff/2", done_o, good_mask_o, clr); end
    abort_i = 1'b1; step(); abort_i = 1'b0;
    total++; if (done_o !== 1'b1 || cfg_bypass_en_o !== 1'b0 || cfg_tx_clear_o !== 1'b0) begin bad++; $display("FAIL abort_in_done: got done=%0b byp=%0b clr=%0b expected 1/0/0", done_o, cfg_bypass_en_o, cfg_tx_clear_o); end
  endtask

  task automatic test_timeout();
    int n;
    bit mid_ok;
    valid_mask = ~(32'h1 << 17);
    tx_idx = 0;
    start_i = 1'b1; step(); start_i = 1'b0;
    step();
    n = 0;
    mid_ok = 1'b0;
    while (!(done_o || fail_o) && n < 1100) begin
      step();
      n++;
      if (n == 1000) mid_ok = (busy_o === 1'b1) && (done_o === 1'b0);
    end
    valid_mask = '1;
    total++; if (!mid_ok) begin bad++; $display("FAIL timeout_wait: got not busy at cycle 1000 expected busy"); end
    total++; if (n < 1024 || n > 1030) begin bad++; $display("FAIL timeout_latency: got %0d cycles after SEND expected 1024..1030", n); end
    total++; if (done_o !== 1'b1 || good_mask_o !== 32'hFFFDFFFF) begin bad++; $display("FAIL timeout_mask: got done=%0b mask=%0h expected 1/fffdffff", done_o, good_mask_o); end
    total++; if (cfg_channel_en_o !== 32'hFFFDFFFF) begin bad++; $display("FAIL timeout_en: got %0h expected fffdffff", cfg_channel_en_o); end
  endtask

  task automatic test_fail();
    int cyc, clr;
    corrupt_all = 1'b1;
    run_training(100, cyc, clr);
    corrupt_all = 1'b0;
    total++; if (fail_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL fail_flags: got fail=%0b done=%0b busy=%0b expected 1/0/0", fail_o, done_o, busy_o); end
    total++; if (cfg_bypass_en_o !== 1'b1 || cfg_channel_en_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL fail_cfg: got byp=%0b en=%0h expected 1/ffffffff", cfg_bypass_en_o, cfg_channel_en_o); end
    total++; if (good_mask_o !== 32'h0 || clr != 1) begin bad++; $display("FAIL fail_mask: got mask=%0h clears=%0d expected 0/1", good_mask_o, clr); end
  endtask

  task automatic test_back_to_back();
    int cyc, clr, n;
    logic [DW-1:0] held;
    logic [15:0] sl;
    bit stable;
    tx_idx = 0;
    start_i = 1'b1; step(); start_i = 1'b0;
    total++; if (fail_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL stall_fail_drop: got fail=%0b busy=%0b expected 0/1", fail_o, busy_o); end
    n = 0;
    while (tx_idx < 4 && n < 50) begin step(); n++; end
    held = train_data_o;
    sl = held[2*EW +: 16];
    total++; if (sl !== 16'h0204 || train_valid_o !== 1'b1) begin bad++; $display("FAIL stall_word: got %0h tv=%0b expected 0204/1", sl, train_valid_o); end
    train_ready_i = 1'b0;
    stable = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      if (train_data_o !== held || train_valid_o !== 1'b1) stable = 1'b0;
    end
    train_ready_i = 1'b1;
    total++; if (!stable) begin bad++; $display("FAIL stall_stable: got data/valid changed expected held"); end
    cyc = 0; clr = 0;
    wait_end(100, cyc, clr);
    total++; if (done_o !== 1'b1 || good_mask_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL stall_pass: got done=%0b mask=%0h expected 1/ffffffff", done_o, good_mask_o); end
    tx_idx = 0;
    start_i = 1'b1; step(); start_i = 1'b0;
    total++; if (done_o !== 1'b0 || cfg_tx_clear_o !== 1'b1) begin bad++; $display("FAIL rerun_done_drop: got done=%0b clr=%0b expected 0/1", done_o, cfg_tx_clear_o); end
    cyc = 0; clr = 0;
    wait_end(100, cyc, clr);
    total++; if (done_o !== 1'b1 || cfg_channel_en_o !== 32'hFFFFFFFF || cfg_bypass_en_o !== 1'b0) begin bad++; $display("FAIL rerun_pass: got done=%0b en=%0h byp=%0b expected 1/ffffffff/0", done_o, cfg_channel_en_o, cfg_bypass_en_o); end
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step();
    test_reset();
    test_ideal();
    test_corrupt_ch5();
    test_abort();
    test_timeout();
    test_fail();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
